// File: rtl/irrigation_zone_scheduler.sv
// Four-zone irrigation scheduler. One zone at a time: prime the valve,
// run the shared pump for the latched length, then an all-off cool-down.
// Grants rotate round-robin; estop aborts to IDLE, ena=0 freezes everything.
module irrigation_zone_scheduler #(
  parameter int PRIME_TICKS = 4,
  parameter int COOL_TICKS  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       tick,
  input  logic [3:0] zone_req,
  input  logic [7:0] run_len,
  input  logic       estop,
  output logic [3:0] valve,
  output logic       pump_on,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       done_pulse
);

  // Tick counter only ever holds 0..N-1: the N-th tick is detected on the
  // compare against N-1 together with tick, so the counter never wraps.
  localparam int MAX_TICKS = (PRIME_TICKS > COOL_TICKS) ? PRIME_TICKS : COOL_TICKS;
  localparam int TW        = (MAX_TICKS < 2) ? 1 : $clog2(MAX_TICKS);
  localparam logic [TW-1:0] PRIME_LAST = TW'(PRIME_TICKS - 1);
  localparam logic [TW-1:0] COOL_LAST  = TW'(COOL_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_WATER = 2'd2,
    S_COOL  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [1:0]      grant_id_q, grant_id_d;
  logic [7:0]      run_cnt_q, run_cnt_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic            done_q, done_d;

  logic [3:0]      req_rot;
  logic [1:0]      pick_off;
  logic            pick_valid;
  logic [1:0]      pick_id;
  logic            in_run;

  // Requests rotated so that bit 0 is the zone rr_ptr points at.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign req_rot[gi] = zone_req[2'(rr_ptr_q + 2'(gi))];
  end

  // First requesting zone at or after rr_ptr.
  always_comb begin
    pick_valid = 1'b1;
    pick_off   = 2'd0;
    if (req_rot[0])      pick_off = 2'd0;
    else if (req_rot[1]) pick_off = 2'd1;
    else if (req_rot[2]) pick_off = 2'd2;
    else if (req_rot[3]) pick_off = 2'd3;
    else                 pick_valid = 1'b0;
    pick_id = rr_ptr_q + pick_off;
  end

  // Next-state logic: estop first, then ena gates every other update.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    run_cnt_d  = run_cnt_q;
    tick_cnt_d = tick_cnt_q;
    done_d     = done_q;
    if (estop) begin
      // Abort: keep rr_ptr and grant_id so the rotation is not disturbed.
      state_d    = S_IDLE;
      run_cnt_d  = 8'd0;
      tick_cnt_d = '0;
      done_d     = 1'b0;
    end else if (ena) begin
      done_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_valid) begin
            state_d    = S_PRIME;
            grant_id_d = pick_id;
            run_cnt_d  = run_len;
            tick_cnt_d = '0;
          end
        end
        S_PRIME: begin
          if (!zone_req[grant_id_q]) begin
            state_d    = S_COOL;
            tick_cnt_d = '0;
            rr_ptr_d   = grant_id_q + 2'd1;
          end else if (tick) begin
            if (tick_cnt_q == PRIME_LAST) begin
              tick_cnt_d = '0;
              if (run_cnt_q == 8'd0) begin
                state_d  = S_COOL;
                rr_ptr_d = grant_id_q + 2'd1;
              end else begin
                state_d  = S_WATER;
              end
            end else begin
              tick_cnt_d = tick_cnt_q + TW'(1);
            end
          end
        end
        S_WATER: begin
          if (!zone_req[grant_id_q]) begin
            // Request withdrawn: stop without signalling completion.
            state_d    = S_COOL;
            tick_cnt_d = '0;
            rr_ptr_d   = grant_id_q + 2'd1;
          end else if (tick) begin
            if (run_cnt_q <= 8'd1) begin
              state_d    = S_COOL;
              run_cnt_d  = 8'd0;
              tick_cnt_d = '0;
              done_d     = 1'b1;
              rr_ptr_d   = grant_id_q + 2'd1;
            end else begin
              run_cnt_d = run_cnt_q - 8'd1;
            end
          end
        end
        S_COOL: begin
          if (tick) begin
            if (tick_cnt_q == COOL_LAST) begin
              state_d    = S_IDLE;
              tick_cnt_d = '0;
            end else begin
              tick_cnt_d = tick_cnt_q + TW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers; synchronous active-low reset overrides ena and estop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= 2'd0;
      grant_id_q <= 2'd0;
      run_cnt_q  <= 8'd0;
      tick_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      run_cnt_q  <= run_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      done_q     <= done_d;
    end
  end

  assign in_run = (state_q == S_PRIME) || (state_q == S_WATER);

  for (genvar gi = 0; gi < 4; gi++) begin : g_valve
    assign valve[gi] = in_run && (grant_id_q == 2'(gi));
  end

  assign pump_on    = (state_q == S_WATER);
  assign busy       = (state_q != S_IDLE);
  assign grant_id   = grant_id_q;
  assign done_pulse = done_q;

endmodule
